bda_load_scheduler: RTL and testbench

Sequencer and arbiter for the branch-destination-address register (a `REGISTER_FLIP_FLOP`-style register with `ClockEnable`, `Tick`, `pre` and tri-state `cs` pins). It sits between the requesters that compute branch targets (branch unit, jump unit, return stack and so on) and that single register. It grants requesters round-robin, drives the register's load, preset and output-enable pins, and tracks whether the held address is still unconsumed by fetch.

---
 rtl/bda_pkg.sv | 15 +
 rtl/bda_load_scheduler_if.sv | 33 +++
 rtl/rr_arbiter_onehot.sv | 35 +++
 rtl/bda_load_scheduler.sv | 134 +++++++++++++
 tb/tb_bda_load_scheduler.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/bda_pkg.sv
// Shared definitions for the branch-destination-address load scheduler:
// FSM encoding, default address width and the fault vector.
package bda_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_PRESET = 2'd2,
    ST_HOLD   = 2'd3
  } bda_state_e;

  localparam int BDA_DEFAULT_BITS = 32;
  localparam logic [BDA_DEFAULT_BITS-1:0] BDA_FAULT_VEC = '1;

endpackage

// File: rtl/bda_load_scheduler_if.sv
// Requester/fetch-side bus of the BDA load scheduler plus the pins that
// drive the destination-address register.
interface bda_load_scheduler_if
  import bda_pkg::*;
#(
  parameter int NrOfBits = BDA_DEFAULT_BITS,
  parameter int NrOfReq  = 4
);
  logic [NrOfReq-1:0]          req;
  logic [NrOfReq*NrOfBits-1:0] req_addr;
  logic                        fault;
  logic                        take;
  logic                        flush;
  logic                        rd_oe;
  logic [NrOfReq-1:0]          gnt;
  logic                        reg_ce;
  logic [NrOfBits-1:0]         reg_d;
  logic                        reg_pre;
  logic                        reg_cs;
  logic                        addr_valid;
  logic                        busy;

  modport master (
    output req, req_addr, fault, take, flush, rd_oe,
    input  gnt, reg_ce, reg_d, reg_pre, reg_cs, addr_valid, busy
  );

  modport slave (
    input  req, req_addr, fault, take, flush, rd_oe,
    output gnt, reg_ce, reg_d, reg_pre, reg_cs, addr_valid, busy
  );

endinterface

// File: rtl/rr_arbiter_onehot.sv
// Combinational round-robin pick: search starts at rr and wraps modulo
// NrOfReq; returns the winner as one-hot and as an index.
module rr_arbiter_onehot #(
  parameter  int NrOfReq = 4,
  localparam int IdxW    = $clog2(NrOfReq)
) (
  input  logic [NrOfReq-1:0] req,
  input  logic [IdxW-1:0]    rr,
  output logic [NrOfReq-1:0] gnt_onehot,
  output logic [IdxW-1:0]    gnt_idx
);

  always_comb begin
    logic          found;
    logic [IdxW:0] sum;
    logic [IdxW-1:0] j;
    found      = 1'b0;
    sum        = '0;
    j          = '0;
    gnt_onehot = '0;
    gnt_idx    = '0;
    for (int k = 0; k < NrOfReq; k++) begin
      // One extra bit so rr+k never overflows before the modulo fold.
      sum = {1'b0, rr} + (IdxW+1)'(k);
      if (sum >= (IdxW+1)'(NrOfReq)) sum = sum - (IdxW+1)'(NrOfReq);
      j = sum[IdxW-1:0];
      if (!found && req[j]) begin
        found         = 1'b1;
        gnt_onehot[j] = 1'b1;
        gnt_idx       = j;
      end
    end
  end

endmodule

// File: rtl/bda_load_scheduler.sv
// Grants branch-target requesters round-robin and sequences load/preset/
// output-enable of the single branch-destination-address register.
module bda_load_scheduler
  import bda_pkg::*;
#(
  parameter int NrOfBits = BDA_DEFAULT_BITS,
  parameter int NrOfReq  = 4
) (
  input logic                 Clock,
  input logic                 Reset,
  input logic                 Tick,
  bda_load_scheduler_if.slave bus
);

  localparam int IdxW = $clog2(NrOfReq);
  localparam logic [NrOfBits-1:0] FaultVec = {NrOfBits{BDA_FAULT_VEC[0]}};

  bda_state_e          state_q, state_d;
  logic [IdxW-1:0]     rr_q, rr_d;
  logic [NrOfReq-1:0]  gnt_q, gnt_d;
  logic                reg_ce_q, reg_ce_d;
  logic [NrOfBits-1:0] reg_d_q, reg_d_d;
  logic                reg_pre_q, reg_pre_d;
  logic                reg_cs_q, reg_cs_d;
  logic                addr_valid_q, addr_valid_d;

  logic [NrOfReq-1:0]  win_onehot;
  logic [IdxW-1:0]     win_idx;
  logic [NrOfBits-1:0] win_addr;
  logic [NrOfBits-1:0] addr_slice [NrOfReq];

  rr_arbiter_onehot #(.NrOfReq(NrOfReq)) u_arb (
    .req        (bus.req),
    .rr         (rr_q),
    .gnt_onehot (win_onehot),
    .gnt_idx    (win_idx)
  );

  // AND-OR mux keyed by the one-hot winner.
  for (genvar gi = 0; gi < NrOfReq; gi++) begin : g_slice
    assign addr_slice[gi] = win_onehot[gi] ? bus.req_addr[gi*NrOfBits +: NrOfBits] : '0;
  end

  always_comb begin
    win_addr = '0;
    for (int i = 0; i < NrOfReq; i++) win_addr = win_addr | addr_slice[i];
  end

  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    gnt_d        = '0;
    reg_ce_d     = 1'b0;
    reg_d_d      = reg_d_q;
    reg_pre_d    = 1'b0;
    addr_valid_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.fault) begin
          state_d   = ST_PRESET;
          reg_pre_d = 1'b1;
          reg_d_d   = FaultVec;
        end else if (Tick && (|bus.req)) begin
          state_d  = ST_LOAD;
          gnt_d    = win_onehot;
          reg_d_d  = win_addr;
          reg_ce_d = 1'b1;
          rr_d     = (win_idx == IdxW'(NrOfReq-1)) ? '0 : win_idx + 1'b1;
        end
      end
      ST_LOAD: begin
        // A fault abandons the load; the issued grant is not replayed.
        if (bus.fault) begin
          state_d   = ST_PRESET;
          reg_pre_d = 1'b1;
          reg_d_d   = FaultVec;
        end else if (Tick) begin
          state_d      = ST_HOLD;
          addr_valid_d = 1'b1;
        end else begin
          reg_ce_d = 1'b1;
        end
      end
      ST_PRESET: begin
        state_d      = ST_HOLD;
        addr_valid_d = 1'b1;
      end
      ST_HOLD: begin
        if (bus.fault) begin
          state_d   = ST_PRESET;
          reg_pre_d = 1'b1;
          reg_d_d   = FaultVec;
        end else if (bus.take || bus.flush) begin
          state_d = ST_IDLE;
        end else begin
          addr_valid_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    reg_cs_d = !((state_d == ST_HOLD) && bus.rd_oe);
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q      <= ST_IDLE;
      rr_q         <= '0;
      gnt_q        <= '0;
      reg_ce_q     <= 1'b0;
      reg_d_q      <= '0;
      reg_pre_q    <= 1'b0;
      reg_cs_q     <= 1'b1;
      addr_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      gnt_q        <= gnt_d;
      reg_ce_q     <= reg_ce_d;
      reg_d_q      <= reg_d_d;
      reg_pre_q    <= reg_pre_d;
      reg_cs_q     <= reg_cs_d;
      addr_valid_q <= addr_valid_d;
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.reg_ce     = reg_ce_q;
  assign bus.reg_d      = reg_d_q;
  assign bus.reg_pre    = reg_pre_q;
  assign bus.reg_cs     = reg_cs_q;
  assign bus.addr_valid = addr_valid_q;
  assign bus.busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_bda_load_scheduler.sv
// Directed bench for bda_load_scheduler with a behavioural model of the
// destination-address register it drives.
module tb_bda_load_scheduler;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  logic Tick  = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] reg_q;
  logic [3:0]  exp_gnt  [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [31:0] exp_addr [5] = '{32'h100, 32'h200, 32'h300, 32'h400, 32'h100};

  bda_load_scheduler_if #(.NrOfBits(32), .NrOfReq(4)) bif ();

  bda_load_scheduler #(.NrOfBits(32), .NrOfReq(4)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .Tick  (Tick),
    .bus   (bif.slave)
  );

  always #5 Clock = ~Clock;

  // Destination-address register: async reset, preset, tick-qualified load.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)                      reg_q <= '0;
    else if (bif.reg_pre)           reg_q <= '1;
    else if (bif.reg_ce && Tick)    reg_q <= bif.reg_d;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("[TB] %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bif.req = '0; bif.req_addr = '0; bif.fault = 0; bif.take = 0; bif.flush = 0; bif.rd_oe = 0;
    repeat (2) @(posedge Clock);
    #1;
    chk("rst_gnt",   32'(bif.gnt), 32'd0);
    chk("rst_ce",    32'(bif.reg_ce), 32'd0);
    chk("rst_d",     bif.reg_d, 32'd0);
    chk("rst_pre",   32'(bif.reg_pre), 32'd0);
    chk("rst_cs",    32'(bif.reg_cs), 32'd1);
    chk("rst_valid", 32'(bif.addr_valid), 32'd0);
    chk("rst_busy",  32'(bif.busy), 32'd0);
    chk("rst_rr",    32'(dut.rr_q), 32'd0);
    Reset = 1'b0;

    // Single load of requester 2
    Tick = 1; bif.req = 4'b0100;
    bif.req_addr = {32'h0, 32'h0000_1040, 32'h0, 32'h0};
    step();
    chk("t1_gnt",  32'(bif.gnt), 32'h4);
    chk("t1_ce",   32'(bif.reg_ce), 32'd1);
    chk("t1_d",    bif.reg_d, 32'h0000_1040);
    chk("t1_busy", 32'(bif.busy), 32'd1);
    bif.req = '0;
    step();
    chk("t1_valid", 32'(bif.addr_valid), 32'd1);
    chk("t1_q",     reg_q, 32'h0000_1040);
    chk("t1_gnt0",  32'(bif.gnt), 32'd0);
    chk("t1_ce0",   32'(bif.reg_ce), 32'd0);
    chk("t1_rr",    32'(dut.rr_q), 32'd3);
    bif.take = 1;
    step();
    chk("t1_exit", 32'(bif.addr_valid), 32'd0);
    bif.take = 0;

    // Round-robin sweep from a fresh pointer, with wrap-around
    Reset = 1; step(); Reset = 0;
    chk("t2_rr0", 32'(dut.rr_q), 32'd0);
    bif.req_addr = {32'h400, 32'h300, 32'h200, 32'h100};
    bif.req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("t2_gnt%0d", i), 32'(bif.gnt), 32'(exp_gnt[i]));
      chk($sformatf("t2_d%0d", i), bif.reg_d, exp_addr[i]);
      step();
      chk($sformatf("t2_q%0d", i), reg_q, exp_addr[i]);
      bif.take = 1;
      step();
      chk($sformatf("t2_idle%0d", i), 32'(bif.busy), 32'd0);
      bif.take = 0;
    end
    bif.req = '0;
    chk("t2_rr", 32'(dut.rr_q), 32'd1);

    // LOAD stalled by Tick=0
    bif.req = 4'b0010;
    step();
    chk("t3_gnt", 32'(bif.gnt), 32'h2);
    bif.req = '0; Tick = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("t3_ce%0d", i), 32'(bif.reg_ce), 32'd1);
      chk($sformatf("t3_q%0d", i), reg_q, 32'h100);
    end
    Tick = 1;
    step();
    chk("t3_valid", 32'(bif.addr_valid), 32'd1);
    chk("t3_q",     reg_q, 32'h200);
    chk("t3_ce0",   32'(bif.reg_ce), 32'd0);
    bif.flush = 1; step(); bif.flush = 0;

    // Fault during LOAD
    bif.req = 4'b1000;
    step();
    chk("t4_gnt", 32'(bif.gnt), 32'h8);
    chk("t4_d",   bif.reg_d, 32'h400);
    bif.req = '0; Tick = 0; bif.fault = 1;
    step();
    chk("t4_ce0",  32'(bif.reg_ce), 32'd0);
    chk("t4_pre",  32'(bif.reg_pre), 32'd1);
    chk("t4_q",    reg_q, 32'h200);
    bif.fault = 0;
    step();
    chk("t4_pre0",  32'(bif.reg_pre), 32'd0);
    chk("t4_valid", 32'(bif.addr_valid), 32'd1);
    chk("t4_qf",    reg_q, 32'hFFFF_FFFF);
    chk("t4_rr",    32'(dut.rr_q), 32'd0);

    // Output enable in HOLD, then flush
    chk("t5_cs1", 32'(bif.reg_cs), 32'd1);
    bif.rd_oe = 1;
    step();
    chk("t5_cs0", 32'(bif.reg_cs), 32'd0);
    chk("t5_q",   reg_q, 32'hFFFF_FFFF);
    bif.flush = 1;
    step();
    chk("t5_cs",    32'(bif.reg_cs), 32'd1);
    chk("t5_valid", 32'(bif.addr_valid), 32'd0);
    chk("t5_busy",  32'(bif.busy), 32'd0);
    bif.flush = 0; bif.rd_oe = 0;

    // Fault beats take in HOLD, then async reset mid-PRESET
    bif.fault = 1;
    step();
    chk("t6_pre", 32'(bif.reg_pre), 32'd1);
    bif.fault = 0;
    step();
    chk("t6_hold", 32'(bif.addr_valid), 32'd1);
    bif.fault = 1; bif.take = 1;
    step();
    chk("t6_pre2",  32'(bif.reg_pre), 32'd1);
    chk("t6_busy",  32'(bif.busy), 32'd1);
    chk("t6_valid", 32'(bif.addr_valid), 32'd0);
    bif.fault = 0; bif.take = 0;
    #3 Reset = 1;
    #1;
    chk("t6_rbusy", 32'(bif.busy), 32'd0);
    chk("t6_rpre",  32'(bif.reg_pre), 32'd0);
    chk("t6_rcs",   32'(bif.reg_cs), 32'd1);
    chk("t6_rd",    bif.reg_d, 32'd0);
    chk("t6_rq",    reg_q, 32'd0);
    chk("t6_rrr",   32'(dut.rr_q), 32'd0);
    @(posedge Clock); #1 Reset = 0;
    step();
    chk("t6_nogrant", 32'(bif.gnt), 32'd0);
    chk("t6_idle",    32'(bif.busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
